// File: rtl/miner_pkg.sv
// Shared state type and default sizing for the nonce-search scheduler.
package miner_pkg;

    localparam int unsigned DEF_NUM_LANES = 10;
    localparam int unsigned DEF_NONCE_W   = 32;
    localparam int unsigned DEF_DIGEST_W  = 256;
    localparam int unsigned HASH_COUNT_W  = 48;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SCAN,
        FOUND,
        EXHAUSTED
    } minerState_t;

endpackage

// File: rtl/digest_scanner.sv
// Per-lane digest capture registers and the serial "digest < target" comparator
// evaluated for one lane index at a time.
module digest_scanner
    import miner_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned DIGEST_W  = DEF_DIGEST_W,
    parameter int unsigned IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_LANES-1:0]          captureEn,
    input  logic [NUM_LANES*DIGEST_W-1:0] laneDigest,
    input  logic [IDX_W-1:0]              scanIdx,
    input  logic [DIGEST_W-1:0]           target,
    output logic                          scanHit_c
);

    logic [DIGEST_W-1:0] digestQ [NUM_LANES];
    logic [DIGEST_W-1:0] selDigest;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_LANES; i++) digestQ[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                if (captureEn[i]) digestQ[i] <= laneDigest[i*DIGEST_W +: DIGEST_W];
        end
    end

    // Explicit mux keeps out-of-range indices (non power-of-two lane counts) harmless
    always_comb begin
        selDigest = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (scanIdx == IDX_W'(i)) selDigest = digestQ[i];
    end

    assign scanHit_c = selDigest < target;

endmodule

// File: rtl/mining_scheduler.sv
// Nonce-search scheduler: launches batches of nonces across external hash lanes and
// scans the results in lane order. Optional hash_count output: MINING_SCHEDULER_HASH_COUNT_EN.
module mining_scheduler
    import miner_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned NONCE_W   = DEF_NONCE_W,
    parameter int unsigned DIGEST_W  = DEF_DIGEST_W
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NONCE_W-1:0]            nonce_start,
    input  logic [NONCE_W-1:0]            nonce_end,
    input  logic [DIGEST_W-1:0]           target,
    output logic [NUM_LANES-1:0]          lane_start,
    output logic [NUM_LANES*NONCE_W-1:0]  lane_nonce,
    input  logic [NUM_LANES-1:0]          lane_done,
    input  logic [NUM_LANES*DIGEST_W-1:0] lane_digest,
    output logic                          busy,
    output logic                          found,
    output logic                          done,
    output logic [NONCE_W-1:0]            found_nonce
`ifdef MINING_SCHEDULER_HASH_COUNT_EN
    ,
    output logic [HASH_COUNT_W-1:0]       hash_count
`endif
);

    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned EXT_W = NONCE_W + 1;

    minerState_t state, nextState;

    logic [NONCE_W-1:0]           base, baseNext, nonceEnd, endNext, foundNonceNext;
    logic [DIGEST_W-1:0]          targetQ, targetNext;
    logic [IDX_W-1:0]             laneIdx, laneIdxNext, scanIdx, scanIdxNext;
    logic [NUM_LANES-1:0]         launched, launchedNext, complete, completeNext;
    logic [NUM_LANES-1:0]         laneStartNext;
    logic [NUM_LANES*NONCE_W-1:0] laneNonceNext;
    logic                         foundNext, doneNext, busyNext, emptyPend, emptyPendNext;

    logic [NUM_LANES-1:0] laneActive_c, launchMask_c, captureEn_c;
    logic idleLike_c, accept_c, allDone_c, batchOver_c, scanLast_c;
    logic scanActive_c, scanHit_c, scanHitLane_c;

    // Lane i carries base+i; compare one bit wider so nonce_end = all-ones never wraps
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++)
            laneActive_c[i] = ({1'b0, base} + EXT_W'(i)) <= {1'b0, nonceEnd};
    end

    assign idleLike_c    = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);
    assign accept_c      = start && !abort && idleLike_c;
    assign launchMask_c  = laneActive_c & (NUM_LANES'(1) << laneIdx);
    assign captureEn_c   = lane_done & launched & ~complete
                         & {NUM_LANES{(state == LAUNCH) || (state == WAIT)}};
    assign allDone_c     = (complete & laneActive_c) == laneActive_c;
    assign batchOver_c   = ({1'b0, base} + EXT_W'(NUM_LANES)) > {1'b0, nonceEnd};
    assign scanLast_c    = scanIdx == IDX_W'(NUM_LANES - 1);
    assign scanActive_c  = |(laneActive_c & (NUM_LANES'(1) << scanIdx));
    assign scanHitLane_c = scanActive_c && scanHit_c;

    digest_scanner #(
        .NUM_LANES (NUM_LANES),
        .DIGEST_W  (DIGEST_W),
        .IDX_W     (IDX_W)
    ) u_scanner (
        .clk        (clk),
        .n_rst      (n_rst),
        .captureEn  (captureEn_c),
        .laneDigest (lane_digest),
        .scanIdx    (scanIdx),
        .target     (targetQ),
        .scanHit_c  (scanHit_c)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE, FOUND, EXHAUSTED:
                    if (start) nextState = (nonce_start > nonce_end) ? EXHAUSTED : LAUNCH;
                LAUNCH:
                    if (laneIdx == IDX_W'(NUM_LANES - 1)) nextState = WAIT;
                WAIT:
                    if (allDone_c) nextState = SCAN;
                SCAN:
                    if (scanHitLane_c)   nextState = FOUND;
                    else if (scanLast_c) nextState = batchOver_c ? EXHAUSTED : LAUNCH;
                default:
                    nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        baseNext       = base;
        endNext        = nonceEnd;
        targetNext     = targetQ;
        laneIdxNext    = laneIdx;
        scanIdxNext    = scanIdx;
        launchedNext   = launched;
        completeNext   = complete | captureEn_c;
        laneStartNext  = '0;
        laneNonceNext  = lane_nonce;
        foundNext      = found;
        doneNext       = done;
        foundNonceNext = found_nonce;
        emptyPendNext  = 1'b0;
        busyNext       = (nextState == LAUNCH) || (nextState == WAIT) || (nextState == SCAN);
        if (abort) begin
            foundNext = 1'b0;
            doneNext  = 1'b0;
        end else begin
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    // Empty range: done rises one cycle after entering EXHAUSTED
                    if (emptyPend) doneNext = 1'b1;
                    if (start) begin
                        baseNext      = nonce_start;
                        endNext       = nonce_end;
                        targetNext    = target;
                        laneIdxNext   = '0;
                        scanIdxNext   = '0;
                        launchedNext  = '0;
                        completeNext  = '0;
                        foundNext     = 1'b0;
                        doneNext      = 1'b0;
                        emptyPendNext = nonce_start > nonce_end;
                    end
                end
                LAUNCH: begin
                    laneStartNext = launchMask_c;
                    launchedNext  = launched | launchMask_c;
                    for (int i = 0; i < NUM_LANES; i++)
                        if (launchMask_c[i])
                            laneNonceNext[i*NONCE_W +: NONCE_W] = base + NONCE_W'(laneIdx);
                    laneIdxNext = laneIdx + IDX_W'(1);
                    scanIdxNext = '0;
                end
                SCAN: begin
                    scanIdxNext = scanIdx + IDX_W'(1);
                    if (scanHitLane_c) begin
                        foundNext      = 1'b1;
                        doneNext       = 1'b1;
                        foundNonceNext = base + NONCE_W'(scanIdx);
                    end else if (scanLast_c) begin
                        if (batchOver_c) begin
                            doneNext = 1'b1;
                        end else begin
                            baseNext     = base + NONCE_W'(NUM_LANES);
                            laneIdxNext  = '0;
                            launchedNext = '0;
                            completeNext = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base        <= '0;
            nonceEnd    <= '0;
            targetQ     <= '0;
            laneIdx     <= '0;
            scanIdx     <= '0;
            launched    <= '0;
            complete    <= '0;
            lane_start  <= '0;
            lane_nonce  <= '0;
            found       <= 1'b0;
            done        <= 1'b0;
            found_nonce <= '0;
            emptyPend   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            base        <= baseNext;
            nonceEnd    <= endNext;
            targetQ     <= targetNext;
            laneIdx     <= laneIdxNext;
            scanIdx     <= scanIdxNext;
            launched    <= launchedNext;
            complete    <= completeNext;
            lane_start  <= laneStartNext;
            lane_nonce  <= laneNonceNext;
            found       <= foundNext;
            done        <= doneNext;
            found_nonce <= foundNonceNext;
            emptyPend   <= emptyPendNext;
            busy        <= busyNext;
        end
    end

`ifdef MINING_SCHEDULER_HASH_COUNT_EN
    logic [HASH_COUNT_W-1:0] hashCount;

    // Active lanes scanned since the last accepted start, saturating
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            hashCount <= '0;
        else if (accept_c)
            hashCount <= '0;
        else if (!abort && (state == SCAN) && scanActive_c && (hashCount != '1))
            hashCount <= hashCount + HASH_COUNT_W'(1);
    end

    assign hash_count = hashCount;
`endif

endmodule

// File: doc/mining_scheduler.md
MINING_SCHEDULER -- requirements
Module: mining_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 10: number of external hash lanes, 1..16.
REQ-002 SHALL have parameter NONCE_W, default 32: nonce width.
REQ-003 SHALL have parameter DIGEST_W, default 256: digest and target width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port n_rst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a search.
REQ-007 SHALL have port abort, input, 1: one-cycle pulse that cancels a search.
REQ-008 SHALL have port nonce_start, input, NONCE_W: first nonce, sampled on start.
REQ-009 SHALL have port nonce_end, input, NONCE_W: last nonce (inclusive), sampled on start.
REQ-010 SHALL have port target, input, DIGEST_W: threshold, sampled on start.
REQ-011 SHALL have port lane_start, output, NUM_LANES: per-lane launch pulse.
REQ-012 SHALL have port lane_nonce, output, NUM_LANES*NONCE_W: per-lane nonce, held stable from launch until that lane's done.
REQ-013 SHALL have port lane_done, input, NUM_LANES: per-lane completion pulse.
REQ-014 SHALL have port lane_digest, input, NUM_LANES*DIGEST_W: per-lane digest, valid when lane_done is high.
REQ-015 SHALL have outputs busy, found and done (1 bit each) and found_nonce (NONCE_W).

Function
REQ-016 SHALL implement states IDLE, LAUNCH, WAIT, SCAN, FOUND, EXHAUSTED.
REQ-017 In IDLE, FOUND or EXHAUSTED, start SHALL register the inputs, set base=nonce_start, clear found/done and enter LAUNCH; start in any other state SHALL be ignored.
REQ-018 Lane i SHALL be active when base+i <= nonce_end, computed NONCE_W+1 wide with no wrap.
REQ-019 LAUNCH SHALL take NUM_LANES cycles; in cycle i it SHALL pulse lane_start[i] only if lane i is active, with lane_nonce[i]=base+i.
REQ-020 WAIT SHALL capture lane_digest[i] on lane_done[i], record lane i as complete, and enter SCAN the cycle after all active lanes are complete.
REQ-021 A lane_done pulse from an inactive or already-complete lane SHALL be ignored.
REQ-022 SCAN SHALL check one lane per cycle in index order 0..NUM_LANES-1, skip inactive lanes, and treat a lane as a hit when its digest < target (strict, unsigned).
REQ-023 On the first hit at index k, the block SHALL set found_nonce=base+k, found=1 and done=1, then enter FOUND; the lowest nonce in the batch wins.
REQ-024 After a scan with no hit, if base+NUM_LANES > nonce_end (NONCE_W+1 wide), the block SHALL set done=1 and found=0 and enter EXHAUSTED; otherwise it SHALL set base+=NUM_LANES and return to LAUNCH.
REQ-025 nonce_end=all-ones SHALL end the search at that nonce and never wrap to 0.
REQ-026 nonce_start > nonce_end SHALL go directly to EXHAUSTED, with no lane launched and done=1 on the second cycle after start.
REQ-027 busy SHALL be 1 in LAUNCH, WAIT and SCAN, and 0 otherwise.
REQ-028 found, done and found_nonce SHALL hold until the next accepted start.
REQ-029 abort SHALL override everything: the block SHALL enter IDLE on the next edge, issue no further lane_start, and leave found=0 and done=0.
REQ-030 If abort and start arrive in the same cycle, abort SHALL win.

Reset
REQ-031 While n_rst=0, state SHALL be IDLE and every output SHALL be 0, asynchronously.
REQ-032 Reset mid-search SHALL discard the search, and no lane_start SHALL be emitted after release until a new start.

Configuration
REQ-033 With MINING_SCHEDULER_HASH_COUNT_EN defined, the block SHALL add output hash_count (48 bits): lanes scanned since the last accepted start, saturating at all-ones, reset to 0.
REQ-034 Without MINING_SCHEDULER_HASH_COUNT_EN, the hash_count port and its counter SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-035 Shared package miner_pkg SHALL hold the state enum type and the default constants (NUM_LANES, NONCE_W, DIGEST_W).
REQ-036 The digest capture registers and the per-lane serial comparator SHALL be sub-module digest_scanner; the FSM, nonce base and launch sequencing SHALL stay in mining_scheduler.

Verification
REQ-037 NUM_LANES=4, start 0x100, end 0x1FF, all digests above target except the digest for nonce 0x10A -> found=1, found_nonce=0x10A, 3 batches launched.
REQ-038 Nonces 0x22 and 0x21 both hit in one batch, with lane 2 done before lane 1 -> found_nonce=0x21.
REQ-039 start 0xFFFFFFFE, end 0xFFFFFFFF, NUM_LANES=4, no hit -> only lanes 0-1 pulse, done=1, found=0, base does not wrap.
REQ-040 start 5, end 3 -> no lane_start, done=1 two cycles after start, busy never 1.
REQ-041 abort in WAIT, then a second start -> idle one cycle later, stale lane_done ignored, new search is correct.
REQ-042 n_rst low during SCAN, then a start with the macro defined -> all outputs 0 during reset, hash_count restarts from 0 and counts correctly.
